// File: rtl/svm_pkg.sv
// Shared definitions for the SVM multiplier arbiter.
// Holds the default parameter values and the FSM state encoding.
package svm_pkg;

  localparam int unsigned SVM_NREQ    = 5;
  localparam int unsigned SVM_W       = 32;
  localparam int unsigned SVM_TMO_CYC = 255;

  localparam logic [2:0] SVM_ST_IDLE      = 3'd0;
  localparam logic [2:0] SVM_ST_ISSUE     = 3'd1;
  localparam logic [2:0] SVM_ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] SVM_ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] SVM_ST_DELIVER   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = SVM_ST_IDLE,
    ST_ISSUE     = SVM_ST_ISSUE,
    ST_WAIT_BUSY = SVM_ST_WAIT_BUSY,
    ST_WAIT_DONE = SVM_ST_WAIT_DONE,
    ST_DELIVER   = SVM_ST_DELIVER
  } svm_state_e;

endpackage

// File: rtl/svm_rr_pick.sv
// Round-robin next-requester search.
// Ports: req   - request vector
//        ptr   - index served last; search starts at ptr+1 (mod NREQ)
//        idx   - first set request found in that order
//        valid - at least one request is set
module svm_rr_pick
  import svm_pkg::*;
#(
  parameter int unsigned NREQ = SVM_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    valid
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // Walk ptr+1 .. ptr+NREQ; the served index itself is visited last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      cand = IW'((int'(ptr) + k) % int'(NREQ));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/svm_mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier among NREQ requesters.
// Ports: clk_svm/rst_svm  - clock, async active-high reset
//        req, op_a, op_b  - request levels and flattened operand pairs
//        gnt, done, err   - one-hot grant, completion pulse, timeout pulse
//        result           - product of the last service
//        mul_a/b/start    - drive to the shared multiplier
//        mul_busy/data    - multiplier status and result
module svm_mul_arbiter
  import svm_pkg::*;
#(
  parameter int unsigned NREQ    = SVM_NREQ,
  parameter int unsigned W       = SVM_W,
  parameter int unsigned TMO_CYC = SVM_TMO_CYC
) (
  input  logic              clk_svm,
  input  logic              rst_svm,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              err,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_start,
  input  logic              mul_busy,
  input  logic [W-1:0]      mul_data
);

  localparam int unsigned IW     = $clog2(NREQ);
  localparam int unsigned WD_RAW = $clog2(TMO_CYC + 1);
  localparam int unsigned WD_W   = (WD_RAW > 8) ? WD_RAW : 8;

  svm_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            busy_q;

  logic [NREQ-1:0] gnt_d, done_d;
  logic [W-1:0]    result_d, mul_a_d, mul_b_d;
  logic            err_d, mul_start_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            busy_fall, wdog_hit;

  logic [W-1:0]    opa_arr [NREQ];
  logic [W-1:0]    opb_arr [NREQ];

  // Unflatten the operand buses so the granted lane can be selected by index.
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign opa_arr[g] = op_a[g*W +: W];
    assign opb_arr[g] = op_b[g*W +: W];
  end

  svm_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign busy_fall = busy_q && !mul_busy;
  assign wdog_hit  = (wdog_q == WD_W'(TMO_CYC));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    wdog_d      = wdog_q;
    gnt_d       = gnt;
    done_d      = '0;
    err_d       = 1'b0;
    result_d    = result;
    mul_a_d     = mul_a;
    mul_b_d     = mul_b;
    mul_start_d = mul_start;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          cur_d           = pick_idx;
          mul_a_d         = opa_arr[pick_idx];
          mul_b_d         = opb_arr[pick_idx];
          // Registered start is high during the ISSUE cycle.
          mul_start_d     = 1'b1;
          state_d         = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d      = '0;
        mul_start_d = 1'b1;
        state_d     = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        wdog_d = wdog_q + WD_W'(1);
        if (wdog_hit) begin
          result_d    = '0;
          mul_start_d = 1'b0;
          done_d      = gnt;
          err_d       = 1'b1;
          state_d     = ST_DELIVER;
        end else if (mul_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        wdog_d = wdog_q + WD_W'(1);
        // A genuine completion wins over a coincident timeout.
        if (busy_fall) begin
          result_d    = mul_data;
          mul_start_d = 1'b0;
          done_d      = gnt;
          state_d     = ST_DELIVER;
        end else if (wdog_hit) begin
          result_d    = '0;
          mul_start_d = 1'b0;
          done_d      = gnt;
          err_d       = 1'b1;
          state_d     = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        ptr_d   = cur_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        mul_start_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_svm or posedge rst_svm) begin
    if (rst_svm) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IW'(NREQ - 1);
      cur_q     <= '0;
      wdog_q    <= '0;
      busy_q    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      result    <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      wdog_q    <= wdog_d;
      busy_q    <= mul_busy;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      result    <= result_d;
      mul_a     <= mul_a_d;
      mul_b     <= mul_b_d;
      mul_start <= mul_start_d;
    end
  end

endmodule

// File: tb/tb_svm_mul_arbiter.sv
// Self-checking bench for svm_mul_arbiter with a behavioural multiplier model.
module tb_svm_mul_arbiter;

  localparam int unsigned NREQ = 5;
  localparam int unsigned W    = 32;
  localparam int unsigned TMO  = 255;
  localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

  logic              clk_svm = 1'b0;
  logic              rst_svm = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [W-1:0]      opa [NREQ];
  logic [W-1:0]      opb [NREQ];
  logic [NREQ*W-1:0] op_a, op_b;
  logic [NREQ-1:0]   gnt, done;
  logic [W-1:0]      result, mul_a, mul_b, mul_data;
  logic              err, mul_start, mul_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_len = 34;
  bit mul_stuck = 1'b0;
  int mdl_last = NREQ - 1;

  logic         start_q;
  int           bcnt;
  logic [W-1:0] prod;

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_pack
    assign op_a[g*W +: W] = opa[g];
    assign op_b[g*W +: W] = opb[g];
  end

  svm_mul_arbiter #(.NREQ(NREQ), .W(W), .TMO_CYC(TMO)) dut (
    .clk_svm   (clk_svm),
    .rst_svm   (rst_svm),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .done      (done),
    .result    (result),
    .err       (err),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_busy  (mul_busy),
    .mul_data  (mul_data)
  );

  always #5 clk_svm = ~clk_svm;
  always @(posedge clk_svm) cyc <= cyc + 1;

  // Multiplier model: busy for busy_len cycles after a start rise; product is
  // presented only in the cycle busy falls, junk otherwise.
  always @(posedge clk_svm) begin
    if (rst_svm) begin
      start_q  <= 1'b0;
      bcnt     <= 0;
      mul_busy <= 1'b0;
      mul_data <= JUNK;
      prod     <= '0;
    end else begin
      start_q <= mul_start;
      if (mul_start && !start_q && !mul_stuck) begin
        bcnt     <= busy_len;
        mul_busy <= 1'b1;
        prod     <= mul_a * mul_b;
        mul_data <= JUNK;
      end else if (bcnt > 1) begin
        bcnt <= bcnt - 1;
      end else if (bcnt == 1) begin
        bcnt     <= 0;
        mul_busy <= 1'b0;
        mul_data <= prod;
      end else begin
        mul_data <= JUNK;
      end
    end
  end

  // Round-robin rule: first requester found scanning upward from last+1.
  function automatic int rr_expect(input logic [NREQ-1:0] r, input int last);
    logic [NREQ-1:0] sh;
    for (int k = 1; k <= int'(NREQ); k++) begin
      sh = r >> ((last + k) % int'(NREQ));
      if (sh[0]) return (last + k) % int'(NREQ);
    end
    return -1;
  endfunction

  // Observe one service (grant through done); no judgement made here.
  task automatic serve_one(input int budget, input bit scramble,
                           output bit ok, output int idx,
                           output logic [W-1:0] a_seen, output logic [W-1:0] b_seen,
                           output logic [W-1:0] res, output logic e, output int lat,
                           output logic [NREQ-1:0] done_seen, output bit stable);
    int  g_cyc;
    bit  got_g;
    logic [NREQ-1:0] g_seen;
    ok = 1'b0; got_g = 1'b0; idx = -1; a_seen = '0; b_seen = '0; res = '0;
    e = 1'b0; lat = -1; done_seen = '0; stable = 1'b1; g_cyc = 0; g_seen = '0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_svm);
      if (got_g && (gnt !== g_seen || mul_a !== a_seen || mul_b !== b_seen)) stable = 1'b0;
      if (!got_g && gnt != '0) begin
        got_g = 1'b1; g_cyc = cyc; g_seen = gnt; a_seen = mul_a; b_seen = mul_b;
        for (int i = 0; i < int'(NREQ); i++) if (gnt[i]) idx = i;
        if ($countones(gnt) != 1) idx = -2;
        if (scramble) for (int i = 0; i < int'(NREQ); i++) begin
          opa[i] = $urandom; opb[i] = $urandom;
        end
      end
      if (done != '0) begin
        done_seen = done; res = result; e = err;
        lat = cyc - (g_cyc - 1); ok = got_g;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk_svm); rst_svm = 1'b1;
    @(negedge clk_svm); rst_svm = 1'b0;
    mdl_last = NREQ - 1;
  endtask

  task automatic test_reset();
    bit got;
    #1 rst_svm = 1'b1;
    opa[0] = 32'd3; opb[0] = 32'd5; busy_len = 34; req = 5'b00001;
    repeat (2) @(negedge clk_svm);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b/%b want 0/0", done, err); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0h want 0", result); end
    checks++; if (mul_start !== 1'b0 || mul_a !== '0 || mul_b !== '0) begin errors++;
      $display("FAIL reset_mul: got start=%b a=%0h b=%0h want 0", mul_start, mul_a, mul_b); end
    rst_svm = 1'b0;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL release_no_early_gnt: got %b want 0", gnt); end
    @(negedge clk_svm);
    checks++; if (gnt !== 5'b00001) begin errors++; $display("FAIL release_first_gnt: got %b want 00001", gnt); end
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_svm);
      if (done != '0) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL release_service_done: got none want done"); end
    req = '0;
    mdl_last = 0;
  endtask

  task automatic test_single();
    int n;
    logic [NREQ-1:0] g1;
    @(negedge clk_svm);
    opa[0] = 32'd3; opb[0] = 32'd5; busy_len = 34; req = 5'b00001;
    n = 0; g1 = '0;
    while (n < 100) begin
      @(negedge clk_svm); n++;
      if (n == 1) g1 = gnt;
      if (done != '0) break;
    end
    req = '0;
    checks++; if (g1 !== 5'b00001) begin errors++; $display("FAIL single_gnt: got %b want 00001", g1); end
    checks++; if (n != 37) begin errors++; $display("FAIL single_latency: got %0d want 37", n); end
    checks++; if (done !== 5'b00001) begin errors++; $display("FAIL single_done: got %b want 00001", done); end
    checks++; if (result !== 32'd15 || err !== 1'b0) begin errors++;
      $display("FAIL single_result: got %0d err=%b want 15 err=0", result, err); end
    @(negedge clk_svm);
    checks++; if (done !== '0 || gnt !== '0) begin errors++;
      $display("FAIL single_release: got done=%b gnt=%b want 0/0", done, gnt); end
    mdl_last = 0;
  endtask

  task automatic test_simultaneous();
    bit ok, st; int idx, lat, ex; logic [W-1:0] a, b, r; logic e; logic [NREQ-1:0] ds;
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin opa[i] = $urandom; opb[i] = $urandom; end
    busy_len = 3;
    req = '1;
    for (int s = 0; s < int'(NREQ); s++) begin
      ex = rr_expect(req, mdl_last);
      serve_one(100, 1'b0, ok, idx, a, b, r, e, lat, ds, st);
      checks++; if (!ok || idx != s || idx != ex) begin errors++;
        $display("FAIL simul_order[%0d]: got %0d want %0d", s, idx, ex); end
      checks++; if (a !== opa[ex] || b !== opb[ex]) begin errors++;
        $display("FAIL simul_operands[%0d]: got %0h,%0h want %0h,%0h", s, a, b, opa[ex], opb[ex]); end
      checks++; if (r !== W'(opa[ex] * opb[ex]) || lat != 6 || !st) begin errors++;
        $display("FAIL simul_result[%0d]: got %0h lat=%0d st=%0b want %0h lat=6 st=1", s, r, lat, st, W'(opa[ex] * opb[ex])); end
      req = req & ~(NREQ'(1) << ex);
      mdl_last = ex;
    end
  endtask

  task automatic test_back_to_back();
    bit ok, st; int idx, lat, ex, prev; logic [W-1:0] a, b, r; logic e; logic [NREQ-1:0] ds;
    int cnt2, cnt3;
    opa[2] = $urandom | 32'd1; opb[2] = $urandom | 32'd1;
    opa[3] = $urandom | 32'd1; opb[3] = $urandom | 32'd1;
    busy_len = $urandom_range(2, 6);
    req = 5'b01100;
    prev = -1; cnt2 = 0; cnt3 = 0;
    for (int s = 0; s < 4; s++) begin
      ex = rr_expect(req, mdl_last);
      serve_one(100, 1'b0, ok, idx, a, b, r, e, lat, ds, st);
      checks++; if (!ok || idx != ex || idx == prev) begin errors++;
        $display("FAIL b2b_grant[%0d]: got %0d want %0d (prev %0d)", s, idx, ex, prev); end
      checks++; if (r !== W'(opa[ex] * opb[ex]) || lat != busy_len + 3) begin errors++;
        $display("FAIL b2b_result[%0d]: got %0h lat=%0d want %0h lat=%0d", s, r, lat, W'(opa[ex] * opb[ex]), busy_len + 3); end
      if (idx == 2) cnt2++;
      if (idx == 3) cnt3++;
      prev = idx; mdl_last = ex;
    end
    req = '0;
    checks++; if (cnt2 != 2 || cnt3 != 2) begin errors++;
      $display("FAIL b2b_fairness: got %0d/%0d want 2/2", cnt2, cnt3); end
  endtask

  task automatic test_watchdog();
    bit ok, st; int idx, lat, ex; logic [W-1:0] a, b, r; logic e; logic [NREQ-1:0] ds;
    mul_stuck = 1'b1;
    opa[1] = $urandom | 32'd1; opb[1] = $urandom | 32'd1;
    req = 5'b00010;
    ex = rr_expect(req, mdl_last);
    serve_one(TMO + 50, 1'b0, ok, idx, a, b, r, e, lat, ds, st);
    req = '0;
    checks++; if (!ok || idx != ex || ds !== (NREQ'(1) << ex)) begin errors++;
      $display("FAIL wdog_done: got idx=%0d done=%b want idx=%0d", idx, ds, ex); end
    checks++; if (lat != int'(TMO) + 3) begin errors++; $display("FAIL wdog_latency: got %0d want %0d", lat, TMO + 3); end
    checks++; if (e !== 1'b1 || r !== '0) begin errors++; $display("FAIL wdog_err_result: got err=%b res=%0h want 1/0", e, r); end
    @(negedge clk_svm);
    checks++; if (gnt !== '0 || mul_start !== 1'b0 || done !== '0 || err !== 1'b0) begin errors++;
      $display("FAIL wdog_idle: got gnt=%b start=%b done=%b err=%b want 0", gnt, mul_start, done, err); end
    mul_stuck = 1'b0;
    mdl_last = ex;
  endtask

  task automatic test_reset_mid();
    bit ok, st, got; int idx, lat, ex, pulses; logic [W-1:0] a, b, r; logic e; logic [NREQ-1:0] ds;
    busy_len = 20;
    opa[2] = 32'd11; opb[2] = 32'd13;
    req = 5'b00100;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_svm);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL rstmid_grant: got none want grant"); end
    repeat (5) @(negedge clk_svm);
    rst_svm = 1'b1;
    #1;
    checks++; if (mul_start !== 1'b0 || gnt !== '0 || done !== '0) begin errors++;
      $display("FAIL rstmid_clear: got start=%b gnt=%b done=%b want 0", mul_start, gnt, done); end
    checks++; if (result !== '0 || err !== 1'b0 || mul_a !== '0) begin errors++;
      $display("FAIL rstmid_regs: got res=%0h err=%b a=%0h want 0", result, err, mul_a); end
    @(negedge clk_svm);
    rst_svm = 1'b0; req = '0; mdl_last = NREQ - 1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_svm);
      if (done != '0) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", pulses); end
    busy_len = 5; opa[4] = 32'd7; opb[4] = 32'd9; req = 5'b10000;
    ex = rr_expect(req, mdl_last);
    serve_one(100, 1'b0, ok, idx, a, b, r, e, lat, ds, st);
    req = '0;
    checks++; if (!ok || idx != ex || r !== 32'd63 || lat != 8 || e !== 1'b0) begin errors++;
      $display("FAIL rstmid_recover: got idx=%0d res=%0d lat=%0d err=%b want %0d/63/8/0", idx, r, lat, e, ex); end
    mdl_last = ex;
  endtask

  task automatic test_one_cycle_busy();
    bit ok, st; int idx, lat, ex; logic [W-1:0] a, b, r; logic e; logic [NREQ-1:0] ds;
    busy_len = 1;
    opa[3] = $urandom; opb[3] = $urandom;
    req = 5'b01000;
    ex = rr_expect(req, mdl_last);
    serve_one(50, 1'b0, ok, idx, a, b, r, e, lat, ds, st);
    req = '0;
    checks++; if (!ok || idx != ex || ds !== (NREQ'(1) << ex)) begin errors++;
      $display("FAIL pulse_done: got idx=%0d done=%b want idx=%0d", idx, ds, ex); end
    checks++; if (r !== W'(opa[ex] * opb[ex]) || lat != 4 || e !== 1'b0) begin errors++;
      $display("FAIL pulse_result: got %0h lat=%0d err=%b want %0h lat=4 err=0", r, lat, e, W'(opa[ex] * opb[ex])); end
    mdl_last = ex;
  endtask

  task automatic test_random();
    bit ok, st; int idx, lat, ex, dur; logic [W-1:0] a, b, r, xa, xb; logic e; logic [NREQ-1:0] ds;
    for (int i = 0; i < int'(NREQ); i++) begin opa[i] = $urandom; opb[i] = $urandom; end
    busy_len = $urandom_range(1, 8);
    req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    for (int s = 0; s < 40; s++) begin
      ex = rr_expect(req, mdl_last);
      xa = opa[ex]; xb = opb[ex]; dur = busy_len;
      serve_one(100, 1'b1, ok, idx, a, b, r, e, lat, ds, st);
      checks++; if (!ok || idx != ex || a !== xa || b !== xb) begin errors++;
        $display("FAIL rand_grant[%0d]: got idx=%0d a=%0h b=%0h want idx=%0d a=%0h b=%0h", s, idx, a, b, ex, xa, xb); end
      checks++; if (r !== W'(xa * xb) || e !== 1'b0 || lat != dur + 3 || !st) begin errors++;
        $display("FAIL rand_result[%0d]: got %0h err=%b lat=%0d st=%0b want %0h err=0 lat=%0d st=1", s, r, e, lat, st, W'(xa * xb), dur + 3); end
      mdl_last = ex;
      if ($urandom_range(0, 1) == 1) req = req & ~(NREQ'(1) << ex);
      req = req | (NREQ'($urandom) & NREQ'($urandom));
      if (req == '0) req = NREQ'(1) << $urandom_range(0, NREQ - 1);
      busy_len = $urandom_range(1, 8);
    end
    req = '0;
  endtask

  initial begin
    for (int i = 0; i < int'(NREQ); i++) begin opa[i] = '0; opb[i] = '0; end
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    test_one_cycle_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish before time limit");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/svm_mul_arbiter.md
SVM_MUL_ARBITER -- requirements
Module: svm_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 5, number of requesters sharing one multiplier (A..E operand pairs).
REQ-002 Parameter W, default 32, operand and result width.
REQ-003 Parameter TMO_CYC, default 255, watchdog limit in cycles per multiply.
REQ-004 clk_svm  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_svm  input  1  reset, asynchronous and active-high.
REQ-006 req  input  NREQ  per-requester request level; held high with operands stable until that requester's done pulse.
REQ-007 op_a  input  NREQ*W  flattened first operands; requester i occupies bits [i*W +: W].
REQ-008 op_b  input  NREQ*W  flattened second operands, same packing as op_a.
REQ-009 gnt  output  NREQ  one-hot grant; held for the whole service of the granted requester.
REQ-010 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-011 result  output  W  product of the last service; valid in the done cycle and held until the next done.
REQ-012 err  output  1  one-cycle watchdog-timeout pulse, coincident with done.
REQ-013 mul_a, mul_b  output  W each  operands driven to the shared multiplier.
REQ-014 mul_start  output  1  multiplier start level; also drives the multiplier's svm_enable.
REQ-015 mul_busy  input  1  multiplier busy flag.
REQ-016 mul_data  input  W  multiplier result; valid on the busy falling edge.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DELIVER.
REQ-018 IDLE: if any req bit is high, pick the first set bit scanning upward from ptr+1 modulo NREQ; set gnt; latch that requester's operands into mul_a/mul_b; go to ISSUE. Otherwise stay in IDLE.
REQ-019 ISSUE: assert mul_start; go to WAIT_BUSY. mul_start therefore first rises one cycle after the IDLE cycle that sampled req.
REQ-020 WAIT_BUSY: hold mul_start high; on mul_busy high, go to WAIT_DONE.
REQ-021 WAIT_DONE: hold mul_start high; detect the falling edge with a registered copy (busy_q && !mul_busy); on the edge, capture mul_data into result, drop mul_start, and go to DELIVER.
REQ-022 DELIVER: pulse done[granted] for one cycle; set ptr to the granted index; clear gnt on exit; return to IDLE.
REQ-023 mul_a, mul_b and gnt stay constant from the IDLE grant until DELIVER exits, so requester operand changes after the grant have no effect.
REQ-024 Arbitration is round-robin. With all NREQ requests held continuously, every index is served exactly once per NREQ services.
REQ-025 A requester that keeps req high after its done is re-eligible in the next IDLE cycle, at lowest priority.
REQ-026 Requests that change while not in IDLE are ignored until the next IDLE cycle.
REQ-027 Watchdog: an 8-bit-or-wider counter clears in ISSUE and increments each cycle in WAIT_BUSY or WAIT_DONE.
REQ-028 When the watchdog counter reaches TMO_CYC: force result to 0, drop mul_start, enter DELIVER, and pulse err together with done.
REQ-029 If the busy rising and falling edges both occur within WAIT_BUSY (a one-cycle busy pulse), the arbiter still completes via WAIT_DONE. The falling-edge detect uses busy_q, which is updated in every state.
REQ-030 Per-service latency from the sampling IDLE cycle to done = 3 + multiplier busy duration (cycles).

Reset
REQ-031 Asserting rst_svm at any time, including mid-multiply, forces the following within the same cycle: state=IDLE, ptr=NREQ-1, gnt=0, done=0, err=0, result=0, mul_start=0, mul_a=0, mul_b=0, busy_q=0, watchdog counter=0.
REQ-032 After rst_svm deasserts, the first grant is issued no earlier than the first rising clk_svm edge.

Structure
REQ-033 State encoding localparams and the default parameter values belong in the shared svm package.
REQ-034 The round-robin next-index search shall be one sub-module, svm_rr_pick (inputs: req, ptr; output: index plus valid).

Verification
REQ-035 Single request: req[0]=1, op_a=3, op_b=5, multiplier model with 34-cycle busy -> gnt=00001, done[0] 37 cycles after the sampling edge, result=15, err=0.
REQ-036 Simultaneous requests: req=11111 immediately after reset -> grant order 0,1,2,3,4, and each operand pair reaches mul_a/mul_b in that order.
REQ-037 Back-to-back service: req[2] and req[3] held continuously -> grants alternate 2,3,2,3; neither requester is starved.
REQ-038 Watchdog: mul_busy tied low -> done and err pulse together TMO_CYC+2 cycles after ISSUE, result=0, FSM returns to IDLE.
REQ-039 Reset mid-operation: rst_svm asserted during WAIT_DONE -> mul_start, gnt and done are 0 in the same cycle; no done pulse follows; a new request after release is served normally.
REQ-040 One-cycle busy pulse: multiplier model asserts busy for exactly 1 cycle -> done is produced, and result equals the mul_data value present on the falling edge.
